// File: rtl/ex_stage_if.sv
// Pipeline-facing bundle of the execute stage: ID/EX operands and controls in,
// EX/MEM result, stall request and overflow exception out.
interface ex_stage_if;
    logic [31:0] in_reg1_data;
    logic [31:0] in_reg2_data;
    logic [4:0]  in_wr_address;
    logic        in_wr_enable;
    logic [7:0]  in_alu_op;
    logic [2:0]  in_alu_sel;
    logic        flush;
    logic        stall_req;
    logic [31:0] out_wr_data;
    logic [4:0]  out_wr_address;
    logic        out_wr_enable;
    logic        ovf_exc;

    modport master (
        output in_reg1_data, in_reg2_data, in_wr_address, in_wr_enable,
        output in_alu_op, in_alu_sel, flush,
        input  stall_req, out_wr_data, out_wr_address, out_wr_enable, ovf_exc
    );

    modport slave (
        input  in_reg1_data, in_reg2_data, in_wr_address, in_wr_enable,
        input  in_alu_op, in_alu_sel, flush,
        output stall_req, out_wr_data, out_wr_address, out_wr_enable, ovf_exc
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS32 execute stage: ALU, HI/LO, 32-step restoring divider, EX/MEM register.
// Define EX_OVF_TRAP_EN to trap signed ADD/SUB overflow via ovf_exc.
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);
    localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_MOVE = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100, SEL_MULDIV = 3'b101;
    localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h20, OP_ADDU = 8'h21, OP_SUB = 8'h22, OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
    localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_rem, r_quo, r_divisor, r_hi, r_lo;
    logic        r_neg_q, r_neg_r, r_div_zero;
    logic [31:0] r_wr_data;
    logic [4:0]  r_wr_address;
    logic        r_wr_enable;

    logic [31:0] w_a, w_b, w_a_abs, w_b_abs, w_sum, w_diff, w_result, w_hi_fix, w_lo_fix;
    logic [63:0] w_mul_a, w_mul_b, w_prod;
    logic [32:0] w_shift, w_trial;
    logic        w_muldiv, w_is_div, w_is_sdiv, w_is_mult, w_mthi, w_mtlo, w_stall;
    logic        w_wr_en, w_ovf;

    assign w_a       = bus.in_reg1_data;
    assign w_b       = bus.in_reg2_data;
    assign w_muldiv  = bus.in_alu_sel == SEL_MULDIV;
    assign w_is_div  = w_muldiv && (bus.in_alu_op == OP_DIV || bus.in_alu_op == OP_DIVU);
    assign w_is_sdiv = bus.in_alu_op == OP_DIV;
    assign w_is_mult = w_muldiv && (bus.in_alu_op == OP_MULT || bus.in_alu_op == OP_MULTU);
    assign w_mthi    = bus.in_alu_sel == SEL_MOVE && bus.in_alu_op == OP_MTHI;
    assign w_mtlo    = bus.in_alu_sel == SEL_MOVE && bus.in_alu_op == OP_MTLO;
    assign w_sum     = w_a + w_b;
    assign w_diff    = w_a - w_b;

    // Sign-extend for MULT so the truncated 64-bit product is the signed result.
    assign w_mul_a = (bus.in_alu_op == OP_MULT) ? {{32{w_a[31]}}, w_a} : {32'b0, w_a};
    assign w_mul_b = (bus.in_alu_op == OP_MULT) ? {{32{w_b[31]}}, w_b} : {32'b0, w_b};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_a_abs = (w_is_sdiv && w_a[31]) ? -w_a : w_a;
    assign w_b_abs = (w_is_sdiv && w_b[31]) ? -w_b : w_b;
    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_divisor};

    // On divide-by-zero r_quo still holds |dividend|, so the sign fix-up restores it.
    assign w_hi_fix = r_div_zero ? (r_neg_r ? -r_quo : r_quo) : (r_neg_r ? -r_rem : r_rem);
    assign w_lo_fix = r_div_zero ? 32'hFFFF_FFFF : (r_neg_q ? -r_quo : r_quo);

    assign w_stall       = (r_state == StIdle && w_is_div) || r_state == StBusy;
    assign bus.stall_req = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (bus.flush) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_is_div) begin
                        r_rem      <= '0;
                        r_quo      <= w_a_abs;
                        r_divisor  <= w_b_abs;
                        r_count    <= '0;
                        r_neg_q    <= w_is_sdiv && (w_a[31] ^ w_b[31]);
                        r_neg_r    <= w_is_sdiv && w_a[31];
                        r_div_zero <= w_b == '0;
                        r_state    <= (w_b == '0) ? StDone : StBusy;
                    end else if (w_is_mult) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (w_mthi) begin
                        r_hi <= w_a;
                    end else if (w_mtlo) begin
                        r_lo <= w_a;
                    end
                end
                StBusy: begin
                    if (!w_trial[32]) begin
                        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'(DIV_CYCLES - 1)) r_state <= StDone;
                end
                StDone: begin
                    r_hi    <= w_hi_fix;
                    r_lo    <= w_lo_fix;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef EX_OVF_TRAP_EN
    logic w_add_ovf, w_sub_ovf;
    assign w_add_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
    assign w_sub_ovf = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
`endif

    always_comb begin
        w_result = '0;
        w_wr_en  = bus.in_wr_enable;
        w_ovf    = 1'b0;
        case (bus.in_alu_sel)
            SEL_LOGIC: begin
                case (bus.in_alu_op)
                    OP_AND:  w_result = w_a & w_b;
                    OP_OR:   w_result = w_a | w_b;
                    OP_XOR:  w_result = w_a ^ w_b;
                    OP_NOR:  w_result = ~(w_a | w_b);
                    default: w_result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (bus.in_alu_op)
                    OP_SLL:  w_result = w_b << w_a[4:0];
                    OP_SRL:  w_result = w_b >> w_a[4:0];
                    OP_SRA:  w_result = $signed(w_b) >>> w_a[4:0];
                    default: w_result = '0;
                endcase
            end
            SEL_MOVE: begin
                case (bus.in_alu_op)
                    OP_MFHI: w_result = r_hi;
                    OP_MFLO: w_result = r_lo;
                    OP_MTHI, OP_MTLO: w_wr_en = 1'b0;
                    default: w_result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (bus.in_alu_op)
                    OP_ADD: begin
                        w_result = w_sum;
`ifdef EX_OVF_TRAP_EN
                        if (w_add_ovf) begin
                            w_wr_en = 1'b0;
                            w_ovf   = 1'b1;
                        end
`endif
                    end
                    OP_SUB: begin
                        w_result = w_diff;
`ifdef EX_OVF_TRAP_EN
                        if (w_sub_ovf) begin
                            w_wr_en = 1'b0;
                            w_ovf   = 1'b1;
                        end
`endif
                    end
                    OP_ADDU: w_result = w_sum;
                    OP_SUBU: w_result = w_diff;
                    OP_SLT:  w_result = {31'b0, $signed(w_a) < $signed(w_b)};
                    OP_SLTU: w_result = {31'b0, w_a < w_b};
                    default: w_result = '0;
                endcase
            end
            SEL_MULDIV: w_wr_en = 1'b0;
            default:    w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_data    <= '0;
            r_wr_address <= '0;
            r_wr_enable  <= 1'b0;
        end else if (bus.flush || w_stall) begin
            r_wr_data    <= '0;
            r_wr_address <= '0;
            r_wr_enable  <= 1'b0;
        end else begin
            r_wr_data    <= w_result;
            r_wr_address <= bus.in_wr_address;
            r_wr_enable  <= w_wr_en;
        end
    end

`ifdef EX_OVF_TRAP_EN
    logic r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= 1'b0;
        else        r_ovf <= w_ovf && !bus.flush && !w_stall;
    end
    assign bus.ovf_exc = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = w_ovf;
    assign bus.ovf_exc  = 1'b0;
`endif

    assign bus.out_wr_data    = r_wr_data;
    assign bus.out_wr_address = r_wr_address;
    assign bus.out_wr_enable  = r_wr_enable;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued as each
// instruction is driven and popped one cycle later when the register updates.
module tb_ex_stage;
    localparam logic [2:0] NOP = 3'b000, LOGIC = 3'b001, SHIFT = 3'b010;
    localparam logic [2:0] MOVE = 3'b011, ARITH = 3'b100, MULDIV = 3'b101;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one instruction at posedge+1, check stall before the edge and the
    // registered outputs just after it.
    task automatic step(input string tag, input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] addr,
                        input logic en, input logic fl, input logic exp_stall,
                        input logic [31:0] exp_data, input logic exp_en, input logic exp_ovf);
        exp_t e;
        bus.in_alu_sel    = sel;
        bus.in_alu_op     = op;
        bus.in_reg1_data  = a;
        bus.in_reg2_data  = b;
        bus.in_wr_address = addr;
        bus.in_wr_enable  = en;
        bus.flush         = fl;
        if (exp_stall || fl) e = '0;
        else e = '{data: exp_data, addr: addr, en: exp_en, ovf: exp_ovf};
        sb_q.push_back(e);
        @(negedge clk);
        check_eq({tag, ".stall"}, {31'b0, bus.stall_req}, {31'b0, exp_stall});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, ".data"}, bus.out_wr_data, e.data);
            check_eq({tag, ".addr"}, {27'b0, bus.out_wr_address}, {27'b0, e.addr});
            check_eq({tag, ".en"}, {31'b0, bus.out_wr_enable}, {31'b0, e.en});
            check_eq({tag, ".ovf"}, {31'b0, bus.ovf_exc}, {31'b0, e.ovf});
        end
        bus.flush = 1'b0;
    endtask

    // Hold a divide for n_stall stalled cycles, then the consuming DONE cycle.
    task automatic div_run(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int n_stall);
        for (int i = 0; i < n_stall; i++)
            step(tag, MULDIV, op, a, b, 5'd9, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        step({tag, ".done"}, MULDIV, op, a, b, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".data"}, bus.out_wr_data, 32'd0);
        check_eq({tag, ".addr"}, {27'b0, bus.out_wr_address}, 32'd0);
        check_eq({tag, ".en"}, {31'b0, bus.out_wr_enable}, 32'd0);
        check_eq({tag, ".stall"}, {31'b0, bus.stall_req}, 32'd0);
        check_eq({tag, ".ovf"}, {31'b0, bus.ovf_exc}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_alu_sel = NOP;
        bus.in_alu_op = 8'h00;
        bus.in_reg1_data = '0;
        bus.in_reg2_data = '0;
        bus.in_wr_address = '0;
        bus.in_wr_enable = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        step("or",   LOGIC, 8'h25, 32'h0F0F_0000, 32'h0000_F0F0, 5'd5, 1'b1, 1'b0, 1'b0,
             32'h0F0F_F0F0, 1'b1, 1'b0);
        step("and",  LOGIC, 8'h24, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd6, 1'b1, 1'b0, 1'b0,
             32'h0F00_0F00, 1'b1, 1'b0);
        step("xor",  LOGIC, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd7, 1'b1, 1'b0, 1'b0,
             32'hF0F0_0F0F, 1'b1, 1'b0);
        step("nor",  LOGIC, 8'h27, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b1, 1'b0);
        step("unk",  LOGIC, 8'h55, 32'h1234, 32'h5678, 5'd10, 1'b1, 1'b0, 1'b0,
             32'h0, 1'b1, 1'b0);
        step("sra",  SHIFT, 8'h03, 32'd4, 32'h8000_0000, 5'd11, 1'b1, 1'b0, 1'b0,
             32'hF800_0000, 1'b1, 1'b0);
        step("srl",  SHIFT, 8'h02, 32'd4, 32'h8000_0000, 5'd12, 1'b1, 1'b0, 1'b0,
             32'h0800_0000, 1'b1, 1'b0);
        step("sll",  SHIFT, 8'h7C, 32'd8, 32'h1, 5'd13, 1'b1, 1'b0, 1'b0,
             32'h0000_0100, 1'b1, 1'b0);
        step("slt",  ARITH, 8'h2A, 32'hFFFF_FFFF, 32'd1, 5'd14, 1'b1, 1'b0, 1'b0,
             32'd1, 1'b1, 1'b0);
        step("sltu", ARITH, 8'h2B, 32'hFFFF_FFFF, 32'd1, 5'd15, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b1, 1'b0);
        step("subu", ARITH, 8'h23, 32'd0, 32'd1, 5'd16, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b1, 1'b0);
        step("addu", ARITH, 8'h21, 32'h7FFF_FFFF, 32'd1, 5'd17, 1'b1, 1'b0, 1'b0,
             32'h8000_0000, 1'b1, 1'b0);
`ifdef EX_OVF_TRAP_EN
        step("add_ovf", ARITH, 8'h20, 32'h7FFF_FFFF, 32'd1, 5'd18, 1'b1, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
        step("sub_ovf", ARITH, 8'h22, 32'h8000_0000, 32'd1, 5'd19, 1'b1, 1'b0, 1'b0,
             32'h7FFF_FFFF, 1'b0, 1'b1);
`else
        step("add_wrap", ARITH, 8'h20, 32'h7FFF_FFFF, 32'd1, 5'd18, 1'b1, 1'b0, 1'b0,
             32'h8000_0000, 1'b1, 1'b0);
        step("sub_wrap", ARITH, 8'h22, 32'h8000_0000, 32'd1, 5'd19, 1'b1, 1'b0, 1'b0,
             32'h7FFF_FFFF, 1'b1, 1'b0);
`endif
        step("add",  ARITH, 8'h20, 32'd5, 32'd7, 5'd20, 1'b1, 1'b0, 1'b0,
             32'd12, 1'b1, 1'b0);
        step("flush_or", LOGIC, 8'h25, 32'hAAAA_0000, 32'h5555, 5'd21, 1'b1, 1'b1, 1'b0,
             32'd0, 1'b0, 1'b0);

        step("mult", MULDIV, 8'h18, 32'hFFFF_FFFF, 32'd2, 5'd22, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b0, 1'b0);
        step("mfhi_mult", MOVE, 8'h10, 32'd0, 32'd0, 5'd23, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b1, 1'b0);
        step("mflo_mult", MOVE, 8'h12, 32'd0, 32'd0, 5'd24, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFE, 1'b1, 1'b0);
        step("multu", MULDIV, 8'h19, 32'hFFFF_FFFF, 32'd2, 5'd22, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b0, 1'b0);
        step("mfhi_multu", MOVE, 8'h10, 32'd0, 32'd0, 5'd23, 1'b1, 1'b0, 1'b0,
             32'h0000_0001, 1'b1, 1'b0);

        div_run("div", 8'h1A, 32'hFFFF_FFF9, 32'd2, 33);
        step("mflo_div", MOVE, 8'h12, 32'd0, 32'd0, 5'd25, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFD, 1'b1, 1'b0);
        step("mfhi_div", MOVE, 8'h10, 32'd0, 32'd0, 5'd26, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b1, 1'b0);

        div_run("divu0", 8'h1B, 32'd7, 32'd0, 1);
        step("mfhi_div0", MOVE, 8'h10, 32'd0, 32'd0, 5'd27, 1'b1, 1'b0, 1'b0,
             32'd7, 1'b1, 1'b0);
        step("mflo_div0", MOVE, 8'h12, 32'd0, 32'd0, 5'd28, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b1, 1'b0);

        div_run("divu", 8'h1B, 32'd100, 32'd7, 33);
        step("mflo_divu", MOVE, 8'h12, 32'd0, 32'd0, 5'd29, 1'b1, 1'b0, 1'b0,
             32'd14, 1'b1, 1'b0);
        step("mfhi_divu", MOVE, 8'h10, 32'd0, 32'd0, 5'd30, 1'b1, 1'b0, 1'b0,
             32'd2, 1'b1, 1'b0);

        // Flush in the 11th BUSY cycle: divider aborts, HI/LO keep MT values.
        step("mthi", MOVE, 8'h11, 32'h1111, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b0, 1'b0);
        step("mtlo", MOVE, 8'h13, 32'h2222, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++)
            step("div_pre_flush", MULDIV, 8'h1A, 32'd100, 32'd3, 5'd9, 1'b1, 1'b0, 1'b1,
                 32'd0, 1'b0, 1'b0);
        step("div_flush", MULDIV, 8'h1A, 32'd100, 32'd3, 5'd9, 1'b1, 1'b1, 1'b1,
             32'd0, 1'b0, 1'b0);
        step("mfhi_flush", MOVE, 8'h10, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0,
             32'h1111, 1'b1, 1'b0);
        step("mflo_flush", MOVE, 8'h12, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0,
             32'h2222, 1'b1, 1'b0);

        // Asynchronous reset during BUSY clears HI/LO and idles the divider.
        for (int i = 0; i < 5; i++)
            step("div_pre_rst", MULDIV, 8'h1A, 32'd100, 32'd3, 5'd9, 1'b1, 1'b0, 1'b1,
                 32'd0, 1'b0, 1'b0);
        bus.in_alu_sel = NOP;
        bus.in_alu_op = 8'h00;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("mfhi_rst", MOVE, 8'h10, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b1, 1'b0);
        step("mflo_rst", MOVE, 8'h12, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0,
             32'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
